// File: rtl/memory_controller_if.sv
// Bundle of the two requester ports and the memory-array side of the controller.
// The controller uses the slave modport; the requester/array side uses master.
interface memory_controller_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    // Requester A
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    // Requester B
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    // Status
    logic              busy;
    // Memory array side
    logic              mem_op;
    logic              mem_select;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output busy,
        output mem_op, mem_select, mem_address, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  busy,
        input  mem_op, mem_select, mem_address, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/memory_controller.sv
// Two-port round-robin request/acknowledge controller in front of the 8x8 memory
// array. Each transaction runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> DONE,
// holding address/op/data stable around a select pulse and returning a one-cycle ack.
module memory_controller #(
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    memory_controller_if.slave  bus
);
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_q, grant_d;          // 0 = A, 1 = B
    logic              last_grant_q, last_grant_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    // State and datapath registers; last_grant resets to B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // Next-state: arbitrate and capture in IDLE, time the select window, update fairness in DONE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.a_req || bus.b_req) begin
                    // On a tie the port that did not win last time is served.
                    grant_d = (bus.a_req && bus.b_req) ? ~last_grant_q : bus.b_req;
                    op_d    = grant_d ? bus.b_we    : bus.a_we;
                    addr_d  = grant_d ? bus.b_addr  : bus.a_addr;
                    wdata_d = grant_d ? bus.b_wdata : bus.a_wdata;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = CNT_LOAD;
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    if (!op_q) begin
                        if (grant_q) begin
                            b_rdata_d = bus.mem_rdata;
                        end else begin
                            a_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from registered state only, so they are glitch-free.
    assign bus.busy        = (state_q != StIdle);
    assign bus.mem_select  = (state_q == StAccess);
    assign bus.mem_op      = op_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.a_ack       = (state_q == StDone) && !grant_q;
    assign bus.b_ack       = (state_q == StDone) && grant_q;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench: one controller with ACCESS_CYCLES=1 and one with ACCESS_CYCLES=3,
// each in front of a small behavioural 8x8 array.
module tb_memory_controller;
    logic clk;
    logic rst1;
    logic rst3;
    int   vectors;
    int   miscompares;

    memory_controller_if #(.ADDR_W(3), .DATA_W(8)) if1 ();
    memory_controller_if #(.ADDR_W(3), .DATA_W(8)) if3 ();

    memory_controller #(.ADDR_W(3), .DATA_W(8), .ACCESS_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1)
    );

    memory_controller #(.ADDR_W(3), .DATA_W(8), .ACCESS_CYCLES(3)) u_dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (if3)
    );

    logic [7:0] mem1 [8];
    logic [7:0] mem3 [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
    end

    // Behavioural arrays: write while selected, combinational read.
    always @(posedge clk) begin
        if (if1.mem_select === 1'b1 && if1.mem_op === 1'b1) mem1[if1.mem_address] <= if1.mem_wdata;
        if (if3.mem_select === 1'b1 && if3.mem_op === 1'b1) mem3[if3.mem_address] <= if3.mem_wdata;
    end
    assign if1.mem_rdata = mem1[if1.mem_address];
    assign if3.mem_rdata = mem3[if3.mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit d3, input bit port, input bit req, input bit we,
                         input logic [2:0] addr, input logic [7:0] wdata);
        if (d3) begin
            if (port) begin
                if3.b_req = req; if3.b_we = we; if3.b_addr = addr; if3.b_wdata = wdata;
            end else begin
                if3.a_req = req; if3.a_we = we; if3.a_addr = addr; if3.a_wdata = wdata;
            end
        end else begin
            if (port) begin
                if1.b_req = req; if1.b_we = we; if1.b_addr = addr; if1.b_wdata = wdata;
            end else begin
                if1.a_req = req; if1.a_we = we; if1.a_addr = addr; if1.a_wdata = wdata;
            end
        end
    endtask

    // Samples each cycle (negedge) until an ack; returns its cycle index, select-high
    // cycles seen, cycles with both acks high, and which port was acked (-1 on timeout).
    task automatic wait_ack(input bit d3, input int start, output int ack_cyc,
                            output int sel_cnt, output int both_cnt, output int gport);
        logic sel, aa, ba;
        ack_cyc  = -1;
        sel_cnt  = 0;
        both_cnt = 0;
        gport    = -1;
        for (int c = start; c < start + 30; c++) begin
            @(negedge clk);
            sel = d3 ? if3.mem_select : if1.mem_select;
            aa  = d3 ? if3.a_ack : if1.a_ack;
            ba  = d3 ? if3.b_ack : if1.b_ack;
            if (sel === 1'b1) sel_cnt++;
            if (aa === 1'b1 && ba === 1'b1) both_cnt++;
            if (aa === 1'b1 || ba === 1'b1) begin
                ack_cyc = c;
                gport   = (ba === 1'b1) ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({if1.busy, if1.mem_select, if1.mem_op, if1.a_ack, if1.b_ack} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000", {if1.busy, if1.mem_select,
                     if1.mem_op, if1.a_ack, if1.b_ack});
        end
        vectors++;
        if ({if1.mem_address, if1.mem_wdata} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_mem_bus: got %h expected 000", {if1.mem_address, if1.mem_wdata});
        end
        vectors++;
        if ({if1.a_rdata, if1.b_rdata} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h expected 0000", {if1.a_rdata, if1.b_rdata});
        end
        vectors++;
        if ({if3.busy, if3.mem_select, if3.a_ack, if3.b_ack} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_dut3: got %b expected 0000", {if3.busy, if3.mem_select,
                     if3.a_ack, if3.b_ack});
        end
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        rst3 = 1'b0;
    endtask

    task automatic test_write_read;
        int ack_cyc, sel_cnt, both_cnt, gport;
        drive(0, 0, 1, 1, 3'd3, 8'hA5);
        @(negedge clk);   // cycle 0: idle
        vectors++;
        if (if1.busy !== 1'b0) begin
            miscompares++; $display("FAIL wr_c0_busy: got %b expected 0", if1.busy);
        end
        @(negedge clk);   // cycle 1: setup
        vectors++;
        if ({if1.busy, if1.mem_address, if1.mem_op, if1.mem_select} !== {1'b1, 3'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_setup: got busy/addr/op/sel %b/%0d/%b/%b expected 1/3/1/0",
                     if1.busy, if1.mem_address, if1.mem_op, if1.mem_select);
        end
        vectors++;
        if (if1.mem_wdata !== 8'hA5) begin
            miscompares++; $display("FAIL wr_setup_wdata: got %h expected a5", if1.mem_wdata);
        end
        @(negedge clk);   // cycle 2: access
        vectors++;
        if ({if1.mem_select, if1.a_ack} !== 2'b10) begin
            miscompares++;
            $display("FAIL wr_access: got sel/ack %b%b expected 10", if1.mem_select, if1.a_ack);
        end
        @(negedge clk);   // cycle 3: done
        vectors++;
        if ({if1.mem_select, if1.a_ack, if1.b_ack} !== 3'b010) begin
            miscompares++;
            $display("FAIL wr_done: got sel/a_ack/b_ack %b%b%b expected 010", if1.mem_select,
                     if1.a_ack, if1.b_ack);
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 3'd0, 8'h00);
        @(negedge clk);
        vectors++;
        if ({if1.a_ack, if1.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_after: got ack/busy %b%b expected 00", if1.a_ack, if1.busy);
        end
        // Read back
        @(posedge clk);
        #1;
        drive(0, 0, 1, 0, 3'd3, 8'h00);
        wait_ack(0, 0, ack_cyc, sel_cnt, both_cnt, gport);
        vectors++;
        if (ack_cyc !== 3 || sel_cnt !== 1 || gport !== 0) begin
            miscompares++;
            $display("FAIL rd_timing: got ack_cyc/sel/port %0d/%0d/%0d expected 3/1/0",
                     ack_cyc, sel_cnt, gport);
        end
        vectors++;
        if (if1.a_rdata !== 8'hA5) begin
            miscompares++; $display("FAIL rd_data: got %h expected a5", if1.a_rdata);
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 3'd0, 8'h00);
    endtask

    task automatic test_back_to_back;
        int ack_cyc, sel_cnt, both_cnt, gport;
        int both_total;
        int exp_port[4] = '{0, 1, 0, 1};
        both_total = 0;
        @(posedge clk);
        #1;
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        drive(0, 0, 1, 0, 3'd3, 8'h00);   // A reads row 3
        drive(0, 1, 1, 1, 3'd5, 8'h5A);   // B writes row 5
        for (int t = 0; t < 4; t++) begin
            wait_ack(0, 0, ack_cyc, sel_cnt, both_cnt, gport);
            both_total += both_cnt;
            vectors++;
            if (gport !== exp_port[t] || ack_cyc !== 3) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got port/ack_cyc %0d/%0d expected %0d/3",
                         t, gport, ack_cyc, exp_port[t]);
            end
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 3'd0, 8'h00);
        drive(0, 1, 0, 0, 3'd0, 8'h00);
        vectors++;
        if (both_total !== 0) begin
            miscompares++; $display("FAIL rr_both_ack: got %0d expected 0", both_total);
        end
        vectors++;
        if ({if1.a_rdata, if1.b_rdata} !== {8'hA5, 8'h00}) begin
            miscompares++;
            $display("FAIL rr_rdata: got a/b %h/%h expected a5/00", if1.a_rdata, if1.b_rdata);
        end
    endtask

    task automatic test_reset_mid_access;
        int ack_cyc, sel_cnt, both_cnt, gport;
        int acks;
        @(posedge clk);
        #1;
        drive(1, 0, 1, 1, 3'd2, 8'h77);
        repeat (3) @(negedge clk);        // cycles 0..2
        @(posedge clk);
        #1;
        rst3 = 1'b1;                      // asserted in second access cycle
        drive(1, 0, 0, 0, 3'd0, 8'h00);
        @(negedge clk);
        vectors++;
        if (if3.mem_select !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre_sel: got %b expected 1", if3.mem_select);
        end
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({if3.mem_select, if3.busy, if3.a_ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_abort: got sel/busy/ack %b%b%b expected 000", if3.mem_select,
                     if3.busy, if3.a_ack);
        end
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if3.a_ack !== 1'b0 || if3.b_ack !== 1'b0 || if3.busy !== 1'b0) acks++;
        end
        vectors++;
        if (acks !== 0) begin
            miscompares++; $display("FAIL rst_no_ack: got %0d active cycles expected 0", acks);
        end
        // Fresh request after the abort
        @(posedge clk);
        #1;
        drive(1, 0, 1, 1, 3'd7, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({if3.busy, if3.mem_select, if3.mem_address, if3.mem_op, if3.mem_wdata} !==
            {1'b1, 1'b0, 3'd7, 1'b1, 8'h3C}) begin
            miscompares++;
            $display("FAIL rst_new_setup: got busy/sel/addr/op/wdata %b/%b/%0d/%b/%h expected 1/0/7/1/3c",
                     if3.busy, if3.mem_select, if3.mem_address, if3.mem_op, if3.mem_wdata);
        end
        wait_ack(1, 2, ack_cyc, sel_cnt, both_cnt, gport);
        vectors++;
        if (ack_cyc !== 5 || sel_cnt !== 3 || gport !== 0) begin
            miscompares++;
            $display("FAIL rst_new_txn: got ack_cyc/sel/port %0d/%0d/%0d expected 5/3/0",
                     ack_cyc, sel_cnt, gport);
        end
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 3'd0, 8'h00);
    endtask

    task automatic test_long_access_read;
        int ack_cyc, sel_cnt, both_cnt, gport;
        @(posedge clk);
        #1;
        drive(1, 1, 1, 0, 3'd7, 8'h00);
        wait_ack(1, 0, ack_cyc, sel_cnt, both_cnt, gport);
        vectors++;
        if (ack_cyc !== 5 || sel_cnt !== 3 || gport !== 1) begin
            miscompares++;
            $display("FAIL long_rd_timing: got ack_cyc/sel/port %0d/%0d/%0d expected 5/3/1",
                     ack_cyc, sel_cnt, gport);
        end
        vectors++;
        if (if3.b_rdata !== 8'h3C) begin
            miscompares++; $display("FAIL long_rd_b: got %h expected 3c", if3.b_rdata);
        end
        vectors++;
        if (if3.a_rdata !== 8'h00) begin
            miscompares++; $display("FAIL long_rd_a_kept: got %h expected 00", if3.a_rdata);
        end
        @(posedge clk);
        #1;
        drive(1, 1, 0, 0, 3'd0, 8'h00);
    endtask

    task automatic test_req_drop;
        int ack_cyc, sel_cnt, both_cnt, gport;
        int extra;
        @(posedge clk);
        #1;
        drive(0, 0, 1, 0, 3'd5, 8'h00);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 3'd0, 8'h00);   // dropped during setup
        wait_ack(0, 1, ack_cyc, sel_cnt, both_cnt, gport);
        vectors++;
        if (ack_cyc !== 3 || gport !== 0) begin
            miscompares++;
            $display("FAIL drop_ack: got ack_cyc/port %0d/%0d expected 3/0", ack_cyc, gport);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if1.a_ack !== 1'b0 || if1.b_ack !== 1'b0 || if1.busy !== 1'b0) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++; $display("FAIL drop_idle: got %0d active cycles expected 0", extra);
        end
        vectors++;
        if ({if1.a_rdata, if1.b_rdata} !== {8'h5A, 8'h00}) begin
            miscompares++;
            $display("FAIL drop_rdata: got a/b %h/%h expected 5a/00", if1.a_rdata, if1.b_rdata);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        drive(0, 0, 0, 0, 3'd0, 8'h00);
        drive(0, 1, 0, 0, 3'd0, 8'h00);
        drive(1, 0, 0, 0, 3'd0, 8'h00);
        drive(1, 1, 0, 0, 3'd0, 8'h00);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_reset_mid_access();
        test_long_access_read();
        test_req_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
